// File: rtl/dmem_be.sv
// Byte-enabled single-port data memory with self-clearing init, load extension
// and misalignment detection; one access per two cycles.
module dmem_be #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int unsigned IdxW = ADDR_W - 2;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [DEPTH];

    logic [IdxW-1:0]   widx;
    logic [1:0]        lane;
    logic              accept;
    logic              misaligned;
    logic [31:0]       rword;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    logic [3:0]        store_be;

    logic              mem_we;
    logic [IdxW-1:0]   mem_idx;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    assign widx   = addr[ADDR_W-1:2];
    assign lane   = addr[1:0];
    assign accept = (state_q == StIdle) && req;

    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = |lane;
            default: misaligned = 1'b1;
        endcase
    end

    // Load path reads the pre-store word; the write below lands on the same edge.
    always_comb begin
        rword     = mem[widx];
        byte_sel  = rword[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? rword[31:16] : rword[15:0];
        load_data = rword;
        unique case (size)
            2'b00:   load_data = {{24{sext & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{sext & half_sel[15]}}, half_sel};
            default: load_data = rword;
        endcase
    end

    always_comb begin
        store_be   = 4'b1111;
        store_data = wdata;
        unique case (size)
            2'b00: begin
                store_be   = 4'b0001 << lane;
                store_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                store_be   = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = wdata;
            end
        endcase
    end

    // Write port is shared between the init sweep and aligned stores; no commit under reset.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = widx;
        mem_wdata = store_data;
        mem_be    = store_be;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_idx   = cnt_q;
            mem_wdata = '0;
            mem_be    = 4'b1111;
        end else if (accept && we && !misaligned) begin
            mem_we = 1'b1;
        end
        mem_we = mem_we & rst_n;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IdxW'(DEPTH - 1)) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (accept) begin
                    state_d  = StResp;
                    ready_d  = 1'b0;
                    rvalid_d = 1'b1;
                    err_d    = misaligned;
                    rdata_d  = (misaligned || we) ? 32'd0 : load_data;
                end
            end
            StResp: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dmem_be.sv
// Scoreboard bench for dmem_be: expected responses are queued at issue and
// compared when rvalid fires; also checks init length, hold behaviour and reset abort.
module tb_dmem_be;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 7;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              req   = 1'b0;
    logic              we    = 1'b0;
    logic [1:0]        size  = 2'b00;
    logic              sext  = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic [31:0]       wdata = '0;
    logic              ready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_rvalid = 0;

    string       tag_q[$];
    logic [32:0] exp_q[$];
    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;

    dmem_be #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .size   (size),
        .sext   (sext),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: pops one expectation per rvalid, checks hold otherwise.
    always @(negedge clk) begin
        string       t;
        logic [32:0] e;
        if (!rst_n) begin
            last_rdata = '0;
            last_err   = 1'b0;
        end else if (rvalid) begin
            n_rvalid++;
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                t = tag_q.pop_front();
                e = exp_q.pop_front();
                check({t, "_rdata"}, rdata, e[31:0]);
                check({t, "_err"}, 32'(err), 32'(e[32]));
            end
            last_rdata = rdata;
            last_err   = err;
        end else begin
            check("hold_rdata", rdata, last_rdata);
            check("hold_err", 32'(err), 32'(last_err));
        end
    end

    task automatic wait_ready(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (ready !== 1'b1 && cycles < 1000);
    endtask

    task automatic access(input string tag, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        int guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) begin
            check({tag, "_ready_timeout"}, 32'(ready), 32'd1);
            return;
        end
        req   = 1'b1;
        we    = w;
        size  = sz;
        sext  = sx;
        addr  = a;
        wdata = wd;
        tag_q.push_back(tag);
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        int last_acc;
        int n_acc;
        int unsigned rv_before;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        wait_ready(cyc);
        check("init_cycles", 32'(cyc), DEPTH);

        for (int i = 0; i < int'(DEPTH); i++) begin
            access($sformatf("lw_clear%0d", i), 1'b0, 2'b10, 1'b0, ADDR_W'(i * 4),
                   32'd0, 32'd0, 1'b0);
        end

        access("sw_04",    1'b1, 2'b10, 1'b0, 7'h04, 32'h1234_5678, 32'd0, 1'b0);
        access("lb_07",    1'b0, 2'b00, 1'b1, 7'h07, 32'd0, 32'h0000_0012, 1'b0);
        access("lhu_06",   1'b0, 2'b01, 1'b0, 7'h06, 32'd0, 32'h0000_1234, 1'b0);
        access("lb_04",    1'b0, 2'b00, 1'b1, 7'h04, 32'd0, 32'h0000_0078, 1'b0);
        access("lw_04",    1'b0, 2'b10, 1'b0, 7'h04, 32'd0, 32'h1234_5678, 1'b0);

        access("sb_09",    1'b1, 2'b00, 1'b0, 7'h09, 32'hFFFF_FF80, 32'd0, 1'b0);
        access("lb_09",    1'b0, 2'b00, 1'b1, 7'h09, 32'd0, 32'hFFFF_FF80, 1'b0);
        access("lbu_09",   1'b0, 2'b00, 1'b0, 7'h09, 32'd0, 32'h0000_0080, 1'b0);
        access("lw_08",    1'b0, 2'b10, 1'b0, 7'h08, 32'd0, 32'h0000_8000, 1'b0);

        access("sw_00",    1'b1, 2'b10, 1'b0, 7'h00, 32'h0BAD_F00D, 32'd0, 1'b0);
        access("sw_mis02", 1'b1, 2'b10, 1'b0, 7'h02, 32'hFFFF_FFFF, 32'd0, 1'b1);
        access("lh_mis03", 1'b0, 2'b01, 1'b1, 7'h03, 32'd0, 32'd0, 1'b1);
        access("st_sz11",  1'b1, 2'b11, 1'b0, 7'h00, 32'hFFFF_FFFF, 32'd0, 1'b1);
        access("ld_sz11",  1'b0, 2'b11, 1'b0, 7'h04, 32'd0, 32'd0, 1'b1);
        access("lw_00",    1'b0, 2'b10, 1'b0, 7'h00, 32'd0, 32'h0BAD_F00D, 1'b0);

        access("sh_0e",    1'b1, 2'b01, 1'b0, 7'h0E, 32'h5555_BEEF, 32'd0, 1'b0);
        access("sh_mis0d", 1'b1, 2'b01, 1'b0, 7'h0D, 32'h0000_1111, 32'd0, 1'b1);
        access("lw_0c",    1'b0, 2'b10, 1'b0, 7'h0C, 32'd0, 32'hBEEF_0000, 1'b0);
        access("lh_0e",    1'b0, 2'b01, 1'b1, 7'h0E, 32'd0, 32'hFFFF_BEEF, 1'b0);
        access("sb_0f",    1'b1, 2'b00, 1'b0, 7'h0F, 32'h0000_0011, 32'd0, 1'b0);
        access("lw_0c_b",  1'b0, 2'b10, 1'b0, 7'h0C, 32'd0, 32'h11EF_0000, 1'b0);

        // Reset asserted on the accepting edge of a store.
        while (ready !== 1'b1) @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        size  = 2'b10;
        addr  = 7'h10;
        wdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        @(negedge clk);
        req = 1'b0;
        check("rst_abort_rvalid", 32'(rvalid), 32'd0);
        check("rst_abort_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(cyc);
        check("reinit_cycles", 32'(cyc), DEPTH);
        access("lw_10",    1'b0, 2'b10, 1'b0, 7'h10, 32'd0, 32'd0, 1'b0);
        access("lw_04_clr", 1'b0, 2'b10, 1'b0, 7'h04, 32'd0, 32'd0, 1'b0);

        // Continuous request from reset: none during init, then every second cycle.
        while (ready !== 1'b1) @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b1;
        we    = 1'b0;
        size  = 2'b10;
        sext  = 1'b0;
        addr  = 7'h04;
        @(negedge clk);
        rst_n     = 1'b1;
        rv_before = n_rvalid;
        n         = 0;
        last_acc  = -1;
        n_acc     = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            n++;
            if (ready === 1'b1) begin
                if (last_acc < 0) check("stream_first_accept", 32'(n), DEPTH);
                else check("stream_spacing", 32'(n - last_acc), 32'd2);
                last_acc = n;
                n_acc++;
                tag_q.push_back("stream");
                exp_q.push_back(33'd0);
            end
        end
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("stream_accepts", 32'(n_acc), 32'd25);
        check("stream_rvalids", n_rvalid - rv_before, 32'(n_acc));
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
